// File: rtl/regbank_pkg.sv
// Shared definitions for the multi-port register bank:
// - the default width constants
// - a helper that gives the register count
// - the reset-contents function
// - the bypass source encoding
package regbank_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_ADDR_W = 3;

  // Widest word the reset-value helper can produce; callers narrow it with a cast.
  localparam int MAX_DATA_W = 64;

  // Where a read port takes its captured value from.
  typedef enum logic [1:0] {
    SRC_STORE = 2'd0,
    SRC_PORT0 = 2'd1,
    SRC_PORT1 = 2'd2,
    SRC_ZERO  = 2'd3
  } bypass_src_e;

  // Number of registers addressed by an addr_w-bit address.
  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  // Register i resets to the value i.
  // The value is zero-extended or truncated to data_w bits.
  function automatic logic [MAX_DATA_W-1:0] reset_value(input int idx, input int data_w);
    logic [MAX_DATA_W-1:0] v;
    v = MAX_DATA_W'(idx);
    for (int b = 0; b < MAX_DATA_W; b++) begin
      if (b >= data_w) begin
        v[b] = 1'b0;
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/regbank_bypass_mux.sv
// Per-read-port forwarding mux.
// It picks the value that the register at addr will hold after the current edge:
// - port 1 write data first,
// - then port 0 write data,
// - then the stored word.
// With REGBANK_ZERO_REG_EN defined, address 0 always reads as zero.
module regbank_bypass_mux
  import regbank_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] stored,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  output logic [DATA_W-1:0] value
);

  bypass_src_e src;

  // Choose the source with the same priority the write logic uses.
  always_comb begin
    src = SRC_STORE;
    if (we1 && (wa1 == addr)) begin
      src = SRC_PORT1;
    end else if (we0 && (wa0 == addr)) begin
      src = SRC_PORT0;
    end
`ifdef REGBANK_ZERO_REG_EN
    if (addr == '0) begin
      src = SRC_ZERO;
    end
`endif
  end

  // Steer the selected source onto the output.
  always_comb begin
    value = stored;
    case (src)
      SRC_PORT1: value = wd1;
      SRC_PORT0: value = wd0;
      SRC_ZERO:  value = '0;
      default:   value = stored;
    endcase
  end

endmodule

// File: rtl/register_bank_mp.sv
// Multi-port register bank.
// - Two registered read ports with write-to-read bypass and a read-valid strobe.
// - Two posedge write ports; port 1 wins when both write the same address.
// - Asynchronous active-low reset loads register[i] = i.
// Optional build macro REGBANK_ZERO_REG_EN makes register 0 a hardwired zero.
module register_bank_mp
  import regbank_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              rdEn,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic [DATA_W-1:0] data1,
  output logic [DATA_W-1:0] data2,
  output logic              rdValid,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DATA_W-1:0] stored_a;
  logic [DATA_W-1:0] stored_b;
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;
  logic              commit0;
  logic              commit1;

  assign stored_a = regs[rs];
  assign stored_b = regs[rt];

  // Writes that actually land in storage.
  // In zero-register builds, writes to address 0 are dropped per port.
  // A port-1 write to 0 therefore never blocks a port-0 write elsewhere.
`ifdef REGBANK_ZERO_REG_EN
  assign commit0 = we0 && (wa0 != '0);
  assign commit1 = we1 && (wa1 != '0);
`else
  assign commit0 = we0;
  assign commit1 = we1;
`endif

  regbank_bypass_mux #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_bypass_a (
    .addr   (rs),
    .stored (stored_a),
    .we0    (we0),
    .wa0    (wa0),
    .wd0    (wd0),
    .we1    (we1),
    .wa1    (wa1),
    .wd1    (wd1),
    .value  (fwd_a)
  );

  regbank_bypass_mux #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_bypass_b (
    .addr   (rt),
    .stored (stored_b),
    .we0    (we0),
    .wa0    (wa0),
    .wd0    (wd0),
    .we1    (we1),
    .wa1    (wa1),
    .wd1    (wd1),
    .value  (fwd_b)
  );

  // Storage update: reset loads index values; otherwise port 1 overrides port 0.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= DATA_W'(reset_value(i, DATA_W));
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (commit1 && (wa1 == ADDR_W'(i))) begin
          regs[i] <= wd1;
        end else if (commit0 && (wa0 == ADDR_W'(i))) begin
          regs[i] <= wd0;
        end
      end
    end
  end

  // Read capture: forwarded values are latched on rdEn.
  // Outputs hold their value otherwise, and rdValid follows rdEn one edge later.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      data1   <= '0;
      data2   <= '0;
      rdValid <= 1'b0;
    end else begin
      rdValid <= rdEn;
      if (rdEn) begin
        data1 <= fwd_a;
        data2 <= fwd_b;
      end
    end
  end

endmodule

// File: tb/tb_register_bank_mp.sv
// Testbench for register_bank_mp.
// - A directed vector table is followed by reset corner sequences.
// - A randomized run is then checked against an array-based model of the register file.
// - Honours REGBANK_ZERO_REG_EN when the design is built with it.
module tb_register_bank_mp;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int NREG = 8;

`ifdef REGBANK_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic          clock;
  logic          resetN;
  logic          rdEn;
  logic [AW-1:0] rs;
  logic [AW-1:0] rt;
  logic [DW-1:0] data1;
  logic [DW-1:0] data2;
  logic          rdValid;
  logic          we0;
  logic [AW-1:0] wa0;
  logic [DW-1:0] wd0;
  logic          we1;
  logic [AW-1:0] wa1;
  logic [DW-1:0] wd1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string         name;
    logic          we0;
    logic [AW-1:0] wa0;
    logic [DW-1:0] wd0;
    logic          we1;
    logic [AW-1:0] wa1;
    logic [DW-1:0] wd1;
    logic          rd_en;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [DW-1:0] exp_d1;
    logic [DW-1:0] exp_d2;
    logic          exp_v;
  } vec_t;

  vec_t vecs [13];

  // Reference model state: plain array of register contents and expected outputs.
  logic [DW-1:0] model_regs [NREG];
  logic [DW-1:0] exp_d1;
  logic [DW-1:0] exp_d2;
  logic          exp_v;

  register_bank_mp #(
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .clock   (clock),
    .resetN  (resetN),
    .rdEn    (rdEn),
    .rs      (rs),
    .rt      (rt),
    .data1   (data1),
    .data2   (data2),
    .rdValid (rdValid),
    .we0     (we0),
    .wa0     (wa0),
    .wd0     (wd0),
    .we1     (we1),
    .wa1     (wa1),
    .wd1     (wd1)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                                input logic re, input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    we0  = w0;
    wa0  = a0;
    wd0  = d0;
    we1  = w1;
    wa1  = a1;
    wd1  = d1;
    rdEn = re;
    rs   = ra;
    rt   = rb;
  endtask

  task automatic idle_inputs();
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic check_all(input string name, input logic [DW-1:0] e1, input logic [DW-1:0] e2, input logic ev);
    check_output({name, ".data1"}, data1, e1);
    check_output({name, ".data2"}, data2, e2);
    check_output({name, ".rdValid"}, {15'd0, rdValid}, {15'd0, ev});
  endtask

  // Model step: apply the edge's writes (port 1 last, so it wins), then capture reads.
  task automatic model_edge();
    if (we0 && !(ZERO_REG && wa0 == 0)) model_regs[wa0] = wd0;
    if (we1 && !(ZERO_REG && wa1 == 0)) model_regs[wa1] = wd1;
    exp_v = rdEn;
    if (rdEn) begin
      exp_d1 = model_regs[rs];
      exp_d2 = model_regs[rt];
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) model_regs[i] = DW'(i);
  endtask

  initial begin
    logic [DW-1:0] z7777;
    logic [DW-1:0] z1111;
    z7777 = ZERO_REG ? 16'h0000 : 16'h7777;
    z1111 = ZERO_REG ? 16'h0000 : 16'h1111;

    vecs[0]  = '{"wr3",      1, 3, 16'hBEEF, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0};
    vecs[1]  = '{"rd3_4",    0, 0, 16'h0000, 0, 0, 16'h0000, 1, 3, 4, 16'hBEEF, 16'h0004, 1};
    vecs[2]  = '{"bypass2",  1, 2, 16'h1234, 0, 0, 16'h0000, 1, 2, 5, 16'h1234, 16'h0005, 1};
    vecs[3]  = '{"collide6", 1, 6, 16'hAAAA, 1, 6, 16'h5555, 1, 2, 6, 16'h1234, 16'h5555, 1};
    vecs[4]  = '{"hold1",    0, 0, 16'h0000, 0, 0, 16'h0000, 0, 7, 7, 16'h1234, 16'h5555, 0};
    vecs[5]  = '{"hold2",    0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 3, 16'h1234, 16'h5555, 0};
    vecs[6]  = '{"hold3",    0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 4, 16'h1234, 16'h5555, 0};
    vecs[7]  = '{"rd6_7",    0, 0, 16'h0000, 0, 0, 16'h0000, 1, 6, 7, 16'h5555, 16'h0007, 1};
    vecs[8]  = '{"dualwr",   1, 4, 16'h4444, 1, 3, 16'h0F0F, 1, 3, 4, 16'h0F0F, 16'h4444, 1};
    vecs[9]  = '{"same_rs",  0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 1, 16'h0001, 16'h0001, 1};
    vecs[10] = '{"wr0_byp",  1, 0, 16'h7777, 0, 0, 16'h0000, 1, 0, 0, z7777,    z7777,    1};
    vecs[11] = '{"rd0",      0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 2, z7777,    16'h1234, 1};
    vecs[12] = '{"p1to0",    1, 5, 16'h5A5A, 1, 0, 16'h1111, 1, 5, 0, 16'h5A5A, z1111,    1};

    idle_inputs();
    resetN = 1'b0;

    // Outputs are defined while reset is held, before any clock edge matters.
    #12;
    check_all("in_reset", 16'h0000, 16'h0000, 1'b0);
    resetN = 1'b1;

    // Directed vector table, one edge per entry.
    @(posedge clock);
    #1;
    for (int k = 0; k < 13; k++) begin
      apply_stimulus(vecs[k].we0, vecs[k].wa0, vecs[k].wd0, vecs[k].we1, vecs[k].wa1, vecs[k].wd1,
                     vecs[k].rd_en, vecs[k].rs, vecs[k].rt);
      @(posedge clock);
      #1;
      check_all(vecs[k].name, vecs[k].exp_d1, vecs[k].exp_d2, vecs[k].exp_v);
    end

    // Make the outputs nonzero so the asynchronous clear is visible.
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 3'd6, 3'd3);
    @(posedge clock);
    #1;
    check_all("pre_rst", 16'h5555, 16'h0F0F, 1'b1);

    // Reset lands between edges alongside a port-1 write and a read.
    apply_stimulus(1'b0, '0, '0, 1'b1, 3'd1, 16'hFFFF, 1'b1, 3'd1, 3'd1);
    #2;
    resetN = 1'b0;
    #1;
    check_all("async_rst", 16'h0000, 16'h0000, 1'b0);
    @(posedge clock);
    #1;
    check_all("rst_edge", 16'h0000, 16'h0000, 1'b0);
    idle_inputs();
    resetN = 1'b1;
    @(posedge clock);
    #1;
    check_all("post_rst", 16'h0000, 16'h0000, 1'b0);

    // The write seen during reset was discarded; contents are back at index values.
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 3'd1, 3'd5);
    @(posedge clock);
    #1;
    check_all("rd1_5", 16'h0001, 16'h0005, 1'b1);

    // Randomized traffic against the model.
    // The model starts from reset contents and the last read.
    model_reset();
    if (ZERO_REG) model_regs[0] = '0;
    exp_d1 = 16'h0001;
    exp_d2 = 16'h0005;
    exp_v  = 1'b1;
    for (int n = 0; n < 400; n++) begin
      apply_stimulus(1'($urandom_range(0, 1)), AW'($urandom_range(0, NREG - 1)), DW'($urandom),
                     1'($urandom_range(0, 1)), AW'($urandom_range(0, NREG - 1)), DW'($urandom),
                     1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, NREG - 1)),
                     AW'($urandom_range(0, NREG - 1)));
      if ($urandom_range(0, 7) == 0) wa1 = wa0;
      if ($urandom_range(0, 7) == 0) rt = rs;
      model_edge();
      @(posedge clock);
      #1;
      check_all("rand", exp_d1, exp_d2, exp_v);
    end

    idle_inputs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/register_bank_mp.md
Name: register_bank_mp

Overview:
- Parametrised multi-port successor to the processor's register bank.
- Provides two registered read ports and two posedge write ports.
- Includes write-to-read bypass, a read-valid strobe and an asynchronous reset to defined contents.
- Sits between decode (rs/rt/rd fields) and ALU/writeback.
- Port 1 serves dual-issue or load-return writeback.

Parameters:
- DATA_W, 16, register and data width in bits.
- ADDR_W, 3, register address width; DEPTH = 2**ADDR_W registers.

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- resetN  in  1  asynchronous, active-low reset.
- rdEn  in  1  read enable; samples both read ports this cycle.
- rs  in  ADDR_W  read port A address.
- rt  in  ADDR_W  read port B address.
- data1  out  DATA_W  registered read data, port A.
- data2  out  DATA_W  registered read data, port B.
- rdValid  out  1  high the cycle after an rdEn sample.
- we0  in  1  write enable, write port 0.
- wa0  in  ADDR_W  write address, port 0.
- wd0  in  DATA_W  write data, port 0.
- we1  in  1  write enable, write port 1.
- wa1  in  ADDR_W  write address, port 1.
- wd1  in  DATA_W  write data, port 1.

Behaviour:

Reset
- clock and reset: one clock; reset is asynchronous and active-low (resetN).
- While resetN=0, immediately and regardless of clock:
  - register[i] = i, zero-extended or truncated to DATA_W.
  - data1 = data2 = 0; rdValid = 0.
- Reset asserted mid-operation discards any same-edge write and any in-flight read.
- First rising edge after release behaves normally.

Writes
- On rising edge: if we0, register[wa0] <= wd0; if we1, register[wa1] <= wd1.
- Both enabled with wa0 == wa1: port 1 wins; port 0 data is dropped.

Reads
- 1-cycle latency: rdEn at edge N -> data1/data2 valid after edge N+1, rdValid=1 for exactly that cycle.
- rdValid <= rdEn every edge.
- rdEn=0: data1/data2 hold their previous values.
- Bypass is evaluated per port using the same-edge write inputs:
  - if we1 && wa1 == addr: captured value = wd1;
  - else if we0 && wa0 == addr: captured value = wd0;
  - else: captured value = register[addr] (pre-edge contents).
  - Priority matches write priority, so the captured value always equals post-edge register content.
- rs == rt is legal; both outputs receive the identical value.
- Addresses cover the full range 0..DEPTH-1 with no out-of-range case.
- No X propagation: every register has a defined reset value.

Optional Feature:
- Macro: REGBANK_ZERO_REG_EN.
- Defined:
  - register 0 is hardwired to 0; writes to address 0 on either port are ignored.
  - Bypass never forwards to address 0; reads of address 0 always return 0.
  - If port 1 targets address 0 and port 0 targets another address, port 0's write still commits.
- Undefined:
  - register 0 is an ordinary register; it resets to 0 and is writable and bypassable like any other.

Decomposition:
- Shared package regbank_pkg:
  - default DATA_W/ADDR_W constants;
  - localparam-style DEPTH helper;
  - function returning the reset value for index i at DATA_W.
- One natural sub-module: regbank_bypass_mux.
  - Combinational; inputs addr, storage word, both write ports; outputs forwarded value.
  - Instantiated once per read port.

Test Plan:
- Reset: pulse resetN low between edges -> immediately register[5]=5 (read rs=5 next cycle gives data1=0x0005), data1/data2/rdValid = 0 during reset.
- Basic write/read: we0, wa0=3, wd0=0xBEEF; next cycle rdEn, rs=3, rt=4 -> after one edge data1=0xBEEF, data2=0x0004, rdValid=1 for one cycle.
- Bypass: same edge we0 wa0=2 wd0=0x1234, rdEn rs=2 -> data1=0x1234 (not 0x0002); register[2]=0x1234 afterwards.
- Write collision: we0 wa0=6 wd0=0xAAAA and we1 wa1=6 wd1=0x5555 with rdEn rt=6 -> data2=0x5555, later read of 6 = 0x5555.
- Hold and reset mid-op: rdEn=0 for 3 cycles -> data1/data2 unchanged, rdValid=0. Then assert resetN low on the same cycle as we1 wa1=1 wd1=0xFFFF -> register[1]=0x0001 after release.
- REGBANK_ZERO_REG_EN: we0 wa0=0 wd0=0x7777 with rdEn rs=0 -> data1=0, later read 0; without macro -> data1=0x7777.
